// File: rtl/fb_sprite_engine.sv
// CHIP-8 framebuffer owner: holds the 64x32 mono image (256 bytes, bit7 = leftmost
// pixel), executes CLS and DXYN sprite draws with collision reporting, and serves a
// read-only display port that runs every cycle.
//
// state  | meaning
// CLEAR  | write 8'h00 to byte clr_cnt, one byte per cycle
// IDLE   | cmd_ready=1, waiting for a command
// ROW_RD | fetch sprite row from main memory, read left framebuffer byte
// ROW_WL | XOR left part of the row, latch right part
// ROW_RR | read right framebuffer byte
// ROW_WR | XOR right part of the row
// FIN    | one-cycle done pulse
module fb_sprite_engine #(
  parameter int FB_BYTES = 256,
  parameter int MEM_AW   = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [3:0]        cmd_n,
  input  logic [MEM_AW-1:0] cmd_i,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              done,
  output logic              collision,
  input  logic [7:0]        disp_addr,
  output logic [7:0]        disp_data
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ROW_RD = 3'd2;
  localparam logic [2:0] S_ROW_WL = 3'd3;
  localparam logic [2:0] S_ROW_RR = 3'd4;
  localparam logic [2:0] S_ROW_WR = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [7:0]        clr_cnt_q, clr_cnt_d;
  logic              clr_cmd_q, clr_cmd_d;   // clear was started by CLS (ends in FIN)
  logic [5:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic [3:0]        n_q, n_d;
  logic [MEM_AW-1:0] i_q, i_d;
  logic [4:0]        r_q, r_d;               // 5 bits so r can reach 16
  logic [7:0]        pr_q, pr_d;
  logic              coll_q, coll_d;

  logic [7:0]        fb_q [FB_BYTES];
  logic [7:0]        a_rdata_q;
  logic [7:0]        disp_data_q;
  logic [7:0]        a_addr, a_wdata;
  logic              a_we;

  logic [5:0]        row_sum, row_inc;
  logic [4:0]        r_inc;
  logic [7:0]        line_addr;
  logic [15:0]       shifted;
  logic              last_row, split_row;
  logic              unused_bits;

  // row index is checked against 32 before it is used, so only [4:0] reaches the address
  assign row_sum   = {1'b0, y_q} + {1'b0, r_q};
  assign r_inc     = r_q + 5'd1;
  assign row_inc   = {1'b0, y_q} + {1'b0, r_inc};
  assign last_row  = (r_inc == {1'b0, n_q}) || (row_inc == 6'd32);
  assign line_addr = {row_sum[4:0], x_q[5:3]};
  assign shifted   = {mem_rdata, 8'h00} >> x_q[2:0];
  assign split_row = (x_q[2:0] != 3'd0) && (x_q[5:3] != 3'd7);
  assign unused_bits = ^{cmd_x[7:6], cmd_y[7:5], row_sum[5]};

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_FIN);
  assign collision = coll_q;
  assign mem_rd    = (state_q == S_ROW_RD);
  assign mem_addr  = i_q + MEM_AW'(r_q);
  assign disp_data = disp_data_q;

  // next-state, command capture and engine-port access
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_cmd_d = clr_cmd_q;
    x_d       = x_q;
    y_d       = y_q;
    n_d       = n_q;
    i_d       = i_q;
    r_d       = r_q;
    pr_d      = pr_q;
    coll_d    = coll_q;
    a_addr    = line_addr;
    a_we      = 1'b0;
    a_wdata   = 8'h00;
    case (state_q)
      S_CLEAR: begin
        a_addr    = clr_cnt_q;
        a_we      = 1'b1;
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'hFF) state_d = clr_cmd_q ? S_FIN : S_IDLE;
      end
      S_IDLE: begin
        if (cmd_valid) begin
          x_d    = cmd_x[5:0];
          y_d    = cmd_y[4:0];
          n_d    = cmd_n;
          i_d    = cmd_i;
          r_d    = 5'd0;
          coll_d = 1'b0;
          if (!cmd_op) begin
            clr_cmd_d = 1'b1;
            clr_cnt_d = 8'd0;
            state_d   = S_CLEAR;
          end else if (cmd_n == 4'd0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ROW_RD;
          end
        end
      end
      S_ROW_RD: state_d = S_ROW_WL;
      S_ROW_WL: begin
        a_we    = 1'b1;
        a_wdata = a_rdata_q ^ shifted[15:8];
        pr_d    = shifted[7:0];
        if ((a_rdata_q & shifted[15:8]) != 8'h00) coll_d = 1'b1;
        if (split_row) begin
          state_d = S_ROW_RR;
        end else begin
          r_d     = r_inc;
          state_d = last_row ? S_FIN : S_ROW_RD;
        end
      end
      S_ROW_RR: begin
        a_addr  = line_addr + 8'd1;
        state_d = S_ROW_WR;
      end
      S_ROW_WR: begin
        a_addr  = line_addr + 8'd1;
        a_we    = 1'b1;
        a_wdata = a_rdata_q ^ pr_q;
        if ((a_rdata_q & pr_q) != 8'h00) coll_d = 1'b1;
        r_d     = r_inc;
        state_d = last_row ? S_FIN : S_ROW_RD;
      end
      S_FIN: begin
        clr_cmd_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // control registers; reset restarts the full clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= 8'd0;
      clr_cmd_q <= 1'b0;
      x_q       <= 6'd0;
      y_q       <= 5'd0;
      n_q       <= 4'd0;
      i_q       <= '0;
      r_q       <= 5'd0;
      pr_q      <= 8'h00;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      clr_cmd_q <= clr_cmd_d;
      x_q       <= x_d;
      y_q       <= y_d;
      n_q       <= n_d;
      i_q       <= i_d;
      r_q       <= r_d;
      pr_q      <= pr_d;
      coll_q    <= coll_d;
    end
  end

  // engine port: write plus registered read (read returns pre-write contents)
  always_ff @(posedge clk) begin
    if (a_we) fb_q[a_addr] <= a_wdata;
    a_rdata_q <= fb_q[a_addr];
  end

  // display port: free-running registered read, old data on write collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) disp_data_q <= 8'h00;
    else          disp_data_q <= fb_q[disp_addr];
  end

endmodule
